shift_seq_ctrl: RTL and testbench
=================================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port CLR, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have port START, input, 1, request to begin one load-and-shift operation.
REQ-004 SHALL have port MODE, input, 2, MODE[0] direction (0 = toward Q[3], 1 = toward Q[0]); MODE[1] fill source (0 = FILL, 1 = rotate).
REQ-005 SHALL have port DIN, input, 4, parallel word to load.
REQ-006 SHALL have port COUNT, input, 3, number of shift steps, 0..7.
REQ-007 SHALL have port FILL, input, 1, constant serial fill bit.
REQ-008 SHALL have port Q_IN, input, 4, feedback of the register's current Q.
REQ-009 SHALL have port S, output, 2, register mode: 00 hold, 01 shift toward Q[3] (Q[0]<-SER), 10 shift toward Q[0] (Q[3]<-SER), 11 parallel load.
REQ-010 SHALL have port D, output, 4, parallel data to the register.
REQ-011 SHALL have port SER, output, 1, serial bit to the register.
REQ-012 SHALL have port BUSY, output, 1, high while an operation is in progress.
REQ-013 SHALL have port DONE, output, 1, one-cycle completion pulse.

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD, SHIFT and FIN.
REQ-015 In IDLE with START=1, SHALL capture MODE, DIN, COUNT and FILL into registers and go to LOAD; while not in IDLE, START SHALL be ignored and the captured values SHALL stay unchanged.
REQ-016 LOAD SHALL last one cycle with S=11 and D equal to the captured DIN, then go to SHIFT if the captured COUNT>0, else to FIN.
REQ-017 SHIFT SHALL last exactly the captured COUNT cycles, with S=01 when direction is 0 and S=10 when direction is 1, then go to FIN.
REQ-018 When fill source is FILL, SER SHALL equal the captured FILL; when fill source is rotate, SER SHALL equal Q_IN[3] for direction 0 and Q_IN[0] for direction 1, combinationally.
REQ-019 FIN SHALL last one cycle with DONE=1 and S=00, then go to IDLE.
REQ-020 Latency SHALL be: START sampled at edge t, LOAD in cycle t+1, shifts in t+2..t+1+COUNT, DONE in t+2+COUNT.
REQ-021 BUSY SHALL be 1 in LOAD and SHIFT and 0 in IDLE and FIN; a START asserted in the FIN cycle SHALL be ignored.
REQ-022 Outside LOAD and SHIFT, S SHALL be 00, and D and SER SHALL be 0 except where REQ-018 applies.

Reset
REQ-023 CLR=1 at a rising edge SHALL force IDLE regardless of state, including mid-SHIFT, and SHALL NOT produce a DONE pulse.
REQ-024 After reset, SHALL hold S=00, D=0000, SER=0, BUSY=0, DONE=0, and all captured registers at 0.
REQ-025 CLR SHALL take priority over START in the same cycle.

Configuration
REQ-026 With macro SHIFT_SEQ_ABORT_EN defined, SHALL add input ABORT (1 bit); ABORT=1 in LOAD or SHIFT SHALL return the FSM to IDLE on the next edge with S=00, no DONE pulse, and BUSY=0.
REQ-027 ABORT SHALL have lower priority than CLR and SHALL be ignored in IDLE and FIN.
REQ-028 Without SHIFT_SEQ_ABORT_EN, the ABORT port and its logic SHALL be absent, and behaviour SHALL be as REQ-014..REQ-025.

Structure
REQ-029 Package shift_seq_pkg SHALL hold the FSM state type, the S-code constants (hold/shift-up/shift-down/load) and the count width constant (3).
REQ-030 Sub-module shift_seq_cnt SHALL provide a 3-bit loadable down-counter with load, decrement and zero-flag outputs, used for the SHIFT duration.

Verification
REQ-031 Bench SHALL cover: reset mid-operation -- CLR=1 during SHIFT -> IDLE next cycle, S=00, BUSY=0, no DONE.
REQ-032 Bench SHALL cover: START, MODE=00, DIN=1010, COUNT=2, FILL=1, with a model 4-bit register -> S=11 one cycle, S=01 two cycles, DONE in cycle t+4, final Q=1011... per model (Q[0]<-1 each step: 1010->0101->1011 with bit-order per S=01 definition).
REQ-033 Bench SHALL cover: MODE=11 (rotate toward Q[0]), DIN=0001, COUNT=1 -> SER=Q_IN[0]=1 during shift, final Q=1000, DONE at t+3.
REQ-034 Bench SHALL cover: COUNT=0, DIN=0110 -> LOAD then FIN, DONE at t+2, Q=0110, no S=01/10 cycle.
REQ-035 Bench SHALL cover: START pulsed during SHIFT and during FIN -> ignored; captured DIN unchanged; exactly one DONE.
REQ-036 Bench SHALL cover (SHIFT_SEQ_ABORT_EN only): COUNT=7 with ABORT at second SHIFT cycle -> IDLE next edge, exactly 2 shift cycles issued, DONE never asserted.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared types and constants for the shift sequencer
//
// Purpose : FSM state type, register S-code constants and the shift count
//           width used by shift_seq_ctrl and shift_seq_cnt.
// Ports   : none (package)
// Config  : none here; SHIFT_SEQ_ABORT_EN is consumed by shift_seq_ctrl.

package shift_seq_pkg;

    // Width of the shift-step count (0..7 steps).
    localparam int CNT_W = 3;

    // S codes driven to the external 4-bit universal shift register.
    localparam logic [1:0] S_HOLD     = 2'b00;  // hold
    localparam logic [1:0] S_SHIFT_UP = 2'b01;  // toward Q[3], Q[0] <- SER
    localparam logic [1:0] S_SHIFT_DN = 2'b10;  // toward Q[0], Q[3] <- SER
    localparam logic [1:0] S_LOAD     = 2'b11;  // parallel load from D

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/shift_seq_cnt.sv
// rtl/shift_seq_cnt.sv - loadable down-counter timing the SHIFT phase
//
// Purpose : 3-bit down-counter. A load takes priority over a decrement,
//           and the counter saturates at zero rather than wrapping.
// Ports   : clk      - clock, rising edge
//           clr      - synchronous active-high clear
//           load     - load load_val on the next edge
//           dec      - decrement on the next edge (ignored at zero)
//           load_val - value to load
//           zero     - high while the count is zero

module shift_seq_cnt
    import shift_seq_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - load-and-shift sequencer for a 4-bit universal shift register
//
// Purpose : On START (in IDLE) captures MODE/DIN/COUNT/FILL, then issues one
//           parallel-load cycle, COUNT shift cycles and a one-cycle DONE.
// Ports   : CLK   - clock, rising edge
//           CLR   - synchronous active-high reset
//           START - begin one operation (honoured in IDLE only)
//           MODE  - [0] direction (0 toward Q[3], 1 toward Q[0]),
//                   [1] fill source (0 FILL, 1 rotate)
//           DIN   - parallel word to load
//           COUNT - number of shift steps, 0..7
//           FILL  - constant serial fill bit
//           Q_IN  - feedback of the register's current Q
//           ABORT - (SHIFT_SEQ_ABORT_EN only) cancel the operation in LOAD/SHIFT
//           S     - register mode code
//           D     - parallel data to the register
//           SER   - serial bit to the register
//           BUSY  - high in LOAD and SHIFT
//           DONE  - one-cycle completion pulse in FIN
// Config  : SHIFT_SEQ_ABORT_EN adds the ABORT input and its logic.

module shift_seq_ctrl
    import shift_seq_pkg::*;
(
    input  logic             CLK,
    input  logic             CLR,
    input  logic             START,
    input  logic [1:0]       MODE,
    input  logic [3:0]       DIN,
    input  logic [CNT_W-1:0] COUNT,
    input  logic             FILL,
    input  logic [3:0]       Q_IN,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             ABORT,
`endif
    output logic [1:0]       S,
    output logic [3:0]       D,
    output logic             SER,
    output logic             BUSY,
    output logic             DONE
);

    state_t state;
    state_t next_state;

    // Operation parameters captured at START; frozen until the next IDLE start.
    logic [1:0]       cap_mode;
    logic [3:0]       cap_din;
    logic [CNT_W-1:0] cap_count;
    logic             cap_fill;

    logic start_acc;
    logic cnt_zero;
    logic [3:0] rot_mask;
    logic rot_bit;

    assign start_acc = (state == ST_IDLE) && START;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state     <= ST_IDLE;
            cap_mode  <= '0;
            cap_din   <= '0;
            cap_count <= '0;
            cap_fill  <= 1'b0;
        end else begin
            state <= next_state;
            if (start_acc) begin
                cap_mode  <= MODE;
                cap_din   <= DIN;
                cap_count <= COUNT;
                cap_fill  <= FILL;
            end
        end
    end

    // The counter is loaded with COUNT-1 during LOAD so that the zero flag
    // marks the last SHIFT cycle. With COUNT=0 the wrapped load value is
    // never used because LOAD goes straight to FIN.
    shift_seq_cnt u_cnt (
        .clk      (CLK),
        .clr      (CLR),
        .load     (state == ST_LOAD),
        .dec      (state == ST_SHIFT),
        .load_val (cap_count - 1'b1),
        .zero     (cnt_zero)
    );

    // Rotate source: the bit leaving the register, Q[3] when shifting toward
    // Q[3] and Q[0] when shifting toward Q[0]. Selected by mask so the whole
    // feedback word takes part in the expression.
    assign rot_mask = cap_mode[0] ? 4'b0001 : 4'b1000;
    assign rot_bit  = |(Q_IN & rot_mask);

    always_comb begin
        next_state = state;
        S          = S_HOLD;
        D          = 4'b0000;
        SER        = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (START) begin
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                S    = S_LOAD;
                D    = cap_din;
                BUSY = 1'b1;
                next_state = (cap_count == '0) ? ST_FIN : ST_SHIFT;
            end
            ST_SHIFT: begin
                S    = cap_mode[0] ? S_SHIFT_DN : S_SHIFT_UP;
                SER  = cap_mode[1] ? rot_bit : cap_fill;
                BUSY = 1'b1;
                if (cnt_zero) begin
                    next_state = ST_FIN;
                end
            end
            ST_FIN: begin
                DONE       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

`ifdef SHIFT_SEQ_ABORT_EN
        // Abort only cancels an operation in flight; FIN completes normally.
        if (ABORT && ((state == ST_LOAD) || (state == ST_SHIFT))) begin
            next_state = ST_IDLE;
        end
`endif
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl

module tb_shift_seq_ctrl;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       START = 1'b0;
    logic [1:0] MODE = 2'b00;
    logic [3:0] DIN = 4'b0000;
    logic [2:0] COUNT = 3'd0;
    logic       FILL = 1'b0;
    logic [3:0] Q_IN;
`ifdef SHIFT_SEQ_ABORT_EN
    logic       ABORT = 1'b0;
`endif
    logic [1:0] S;
    logic [3:0] D;
    logic       SER;
    logic       BUSY;
    logic       DONE;

    int checks = 0;
    int errors = 0;

    // External 4-bit universal shift register driven by the sequencer.
    logic [3:0] q = 4'b0000;
    assign Q_IN = q;

    always @(posedge CLK) begin
        case (S)
            2'b01:   q <= {q[2:0], SER};
            2'b10:   q <= {SER, q[3:1]};
            2'b11:   q <= D;
            default: q <= q;
        endcase
    end

    always #5 CLK = ~CLK;

    shift_seq_ctrl dut (
        .CLK   (CLK),
        .CLR   (CLR),
        .START (START),
        .MODE  (MODE),
        .DIN   (DIN),
        .COUNT (COUNT),
        .FILL  (FILL),
        .Q_IN  (Q_IN),
`ifdef SHIFT_SEQ_ABORT_EN
        .ABORT (ABORT),
`endif
        .S     (S),
        .D     (D),
        .SER   (SER),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Final register contents from the operation's definition: n shifts with
    // a constant fill, or a rotation by n mod 4.
    function automatic logic [3:0] ref_q(input logic [1:0] mode, input logic [3:0] din,
                                         input int n, input logic fill);
        int v;
        int r;
        v = int'(din);
        if (mode[1]) begin
            r = n % 4;
            if (!mode[0]) v = ((v << r) | (v >> (4 - r))) & 15;
            else          v = ((v >> r) | (v << (4 - r))) & 15;
        end else if (n >= 4) begin
            v = fill ? 15 : 0;
        end else if (!mode[0]) begin
            v = ((v << n) | (fill ? ((1 << n) - 1) : 0)) & 15;
        end else begin
            v = (v >> n) | (fill ? ((15 << (4 - n)) & 15) : 0);
        end
        return v[3:0];
    endfunction

    // One full operation; cycle k=1 is the cycle after the START edge.
    task automatic run_op(input string tag, input logic [1:0] mode, input logic [3:0] din,
                          input logic [2:0] count, input logic fill,
                          input logic [3:0] exp_q, input int lat);
        int dones;
        logic [1:0] exp_s;
        logic exp_ser;
        dones = 0;
        START = 1'b1; MODE = mode; DIN = din; COUNT = count; FILL = fill;
        tick();
        START = 1'b0;
        MODE = 2'($urandom); DIN = 4'($urandom); COUNT = 3'($urandom); FILL = 1'($urandom);
        for (int k = 1; k <= lat + 1; k++) begin
            if (k == 1)       exp_s = 2'b11;
            else if (k < lat) exp_s = mode[0] ? 2'b10 : 2'b01;
            else              exp_s = 2'b00;
            check({tag, "/S"}, 8'(S), 8'(exp_s));
            check({tag, "/BUSY"}, 8'(BUSY), 8'(k < lat));
            check({tag, "/DONE"}, 8'(DONE), 8'(k == lat));
            check({tag, "/D"}, 8'(D), (k == 1) ? 8'(din) : 8'h00);
            if (k > 1 && k < lat) begin
                exp_ser = mode[1] ? (mode[0] ? q[0] : q[3]) : fill;
                check({tag, "/SER"}, 8'(SER), 8'(exp_ser));
            end
            if (DONE === 1'b1) dones++;
            tick();
        end
        check({tag, "/Q"}, 8'(q), 8'(exp_q));
        check({tag, "/ndone"}, 8'(dones), 8'd1);
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [3:0] din;
        logic [2:0] count;
        logic       fill;
        logic [3:0] exp_q;
        int         lat;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int dones;
        int shifts;
        logic [1:0] m;
        logic [3:0] di;
        logic [2:0] c;
        logic f;

        tbl[0] = '{2'b00, 4'b1010, 3'd2, 1'b1, 4'b1011, 4};
        tbl[1] = '{2'b11, 4'b0001, 3'd1, 1'b0, 4'b1000, 3};
        tbl[2] = '{2'b00, 4'b0110, 3'd0, 1'b1, 4'b0110, 2};
        tbl[3] = '{2'b01, 4'b1111, 3'd3, 1'b0, 4'b0001, 5};
        tbl[4] = '{2'b10, 4'b1000, 3'd3, 1'b0, 4'b0100, 5};
        tbl[5] = '{2'b00, 4'b0000, 3'd7, 1'b1, 4'b1111, 9};
        tbl[6] = '{2'b11, 4'b1001, 3'd5, 1'b0, 4'b1100, 7};

        // Reset state
        tick(); tick();
        check("rst/S", 8'(S), 8'h00);
        check("rst/D", 8'(D), 8'h00);
        check("rst/SER", 8'(SER), 8'h00);
        check("rst/BUSY", 8'(BUSY), 8'h00);
        check("rst/DONE", 8'(DONE), 8'h00);
        CLR = 1'b0;
        tick();

        foreach (tbl[i]) begin
            run_op($sformatf("vec%0d", i), tbl[i].mode, tbl[i].din, tbl[i].count,
                   tbl[i].fill, tbl[i].exp_q, tbl[i].lat);
        end

        for (int i = 0; i < 24; i++) begin
            m  = 2'($urandom_range(0, 3));
            di = 4'($urandom);
            c  = 3'($urandom_range(0, 7));
            f  = 1'($urandom);
            run_op($sformatf("rnd%0d", i), m, di, c, f, ref_q(m, di, int'(c), f), int'(c) + 2);
        end

        // CLR during SHIFT: back to IDLE with no DONE
        START = 1'b1; MODE = 2'b00; DIN = 4'b1111; COUNT = 3'd5; FILL = 1'b0;
        tick();
        START = 1'b0;
        tick(); tick();
        check("clr/pre_S", 8'(S), 8'h01);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        check("clr/S", 8'(S), 8'h00);
        check("clr/BUSY", 8'(BUSY), 8'h00);
        check("clr/DONE", 8'(DONE), 8'h00);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            if (DONE === 1'b1 || BUSY === 1'b1) dones++;
            tick();
        end
        check("clr/quiet", 8'(dones), 8'd0);

        // CLR beats START in the same cycle
        START = 1'b1; CLR = 1'b1;
        tick();
        START = 1'b0; CLR = 1'b0;
        check("clrprio/BUSY", 8'(BUSY), 8'h00);
        check("clrprio/S", 8'(S), 8'h00);
        tick();
        check("clrprio/BUSY2", 8'(BUSY), 8'h00);

        // START during SHIFT and during FIN is ignored
        dones = 0;
        START = 1'b1; MODE = 2'b00; DIN = 4'b1010; COUNT = 3'd2; FILL = 1'b1;
        tick();
        START = 1'b0;
        tick();
        START = 1'b1; MODE = 2'b11; DIN = 4'b0000; COUNT = 3'd7; FILL = 1'b0;
        tick();
        START = 1'b0;
        check("ign/S_shift2", 8'(S), 8'h01);
        check("ign/SER_shift2", 8'(SER), 8'h01);
        tick();
        check("ign/DONE_fin", 8'(DONE), 8'h01);
        if (DONE === 1'b1) dones++;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("ign/BUSY_after_fin", 8'(BUSY), 8'h00);
        check("ign/S_after_fin", 8'(S), 8'h00);
        for (int k = 0; k < 10; k++) begin
            if (DONE === 1'b1) dones++;
            tick();
        end
        check("ign/ndone", 8'(dones), 8'd1);
        check("ign/Q", 8'(q), 8'hb);

`ifdef SHIFT_SEQ_ABORT_EN
        // ABORT at the second SHIFT cycle of a 7-step operation
        dones = 0; shifts = 0;
        START = 1'b1; MODE = 2'b00; DIN = 4'b0000; COUNT = 3'd7; FILL = 1'b1;
        tick();
        START = 1'b0;
        tick();
        if (S == 2'b01) shifts++;
        tick();
        if (S == 2'b01) shifts++;
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("abort/S", 8'(S), 8'h00);
        check("abort/BUSY", 8'(BUSY), 8'h00);
        for (int k = 0; k < 10; k++) begin
            if (S == 2'b01 || S == 2'b10) shifts++;
            if (DONE === 1'b1) dones++;
            tick();
        end
        check("abort/nshift", 8'(shifts), 8'd2);
        check("abort/ndone", 8'(dones), 8'd0);
        check("abort/Q", 8'(q), 8'h3);

        // ABORT in IDLE does not block a START
        START = 1'b1; ABORT = 1'b1; COUNT = 3'd1;
        tick();
        START = 1'b0; ABORT = 1'b0;
        check("abort_idle/S", 8'(S), 8'h03);
        check("abort_idle/BUSY", 8'(BUSY), 8'h01);
        for (int k = 0; k < 4; k++) tick();
`else
        shifts = 0;
        check("noabort/shifts", 8'(shifts + int'(BUSY)), 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
